// File: rtl/mips_if2id_buf.sv
// mips_if2id_buf: two-entry skid buffer between instruction fetch and decode.
// The head entry drives the decode-side outputs directly. The skid entry
// catches the one extra instruction that fetch may still deliver in the cycle
// in which decode stalls, so nothing returned by the I-cache is lost.
module mips_if2id_buf #(
    parameter int          AW  = 32,
    parameter int          DW  = 32,
    parameter logic [DW-1:0] NOP = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [DW-1:0] if_inst,
    input  logic [AW-1:0] if_pc,
    input  logic          if_prdt_taken,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [DW-1:0] id_inst,
    output logic [AW-1:0] id_pc,
    output logic          id_prdt_taken,
    output logic [1:0]    occupancy
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // Registered state
    logic [1:0]    count_q,      count_d;
    logic [DW-1:0] head_inst_q,  head_inst_d;
    logic [AW-1:0] head_pc_q,    head_pc_d;
    logic          head_taken_q, head_taken_d;
    logic [DW-1:0] skid_inst_q,  skid_inst_d;
    logic [AW-1:0] skid_pc_q,    skid_pc_d;
    logic          skid_taken_q, skid_taken_d;

    logic push;
    logic pop;

    // Handshake flags depend only on registered count, never on the inputs'
    // valid/ready, so there is no combinational path through this stage.
    assign if_ready  = (count_q != CNT_FULL);
    assign id_valid  = (count_q != CNT_EMPTY);
    assign occupancy = count_q;

    assign push = if_valid & if_ready;
    assign pop  = id_valid & id_ready;

    // Decode sees a NOP whenever nothing valid is held; pc/prediction are
    // left at their last value because decode ignores them when invalid.
    assign id_inst       = id_valid ? head_inst_q : NOP;
    assign id_pc         = head_pc_q;
    assign id_prdt_taken = head_taken_q;

    // Next-state: flush wins over everything, otherwise move entries
    // so the oldest instruction always sits in the head register.
    always_comb begin
        count_d      = count_q;
        head_inst_d  = head_inst_q;
        head_pc_d    = head_pc_q;
        head_taken_d = head_taken_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_taken_d = skid_taken_q;

        if (flush) begin
            count_d = CNT_EMPTY;
        end else begin
            unique case (count_q)
                CNT_EMPTY: begin
                    if (push) begin
                        count_d      = CNT_ONE;
                        head_inst_d  = if_inst;
                        head_pc_d    = if_pc;
                        head_taken_d = if_prdt_taken;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        head_inst_d  = if_inst;
                        head_pc_d    = if_pc;
                        head_taken_d = if_prdt_taken;
                    end else if (push) begin
                        count_d      = CNT_FULL;
                        skid_inst_d  = if_inst;
                        skid_pc_d    = if_pc;
                        skid_taken_d = if_prdt_taken;
                    end else if (pop) begin
                        count_d = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (pop) begin
                        count_d      = CNT_ONE;
                        head_inst_d  = skid_inst_q;
                        head_pc_d    = skid_pc_q;
                        head_taken_d = skid_taken_q;
                    end
                end
                default: begin
                    count_d = CNT_EMPTY;
                end
            endcase
        end
    end

    // State registers with asynchronous reset to an empty, zeroed buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= CNT_EMPTY;
            head_inst_q  <= '0;
            head_pc_q    <= '0;
            head_taken_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            skid_taken_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            head_inst_q  <= head_inst_d;
            head_pc_q    <= head_pc_d;
            head_taken_q <= head_taken_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_taken_q <= skid_taken_d;
        end
    end

    // Structural invariants of the buffer.
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q != 2'd3);
    a_ready_full: assert property (@(posedge clk) disable iff (!rst_n)
        !if_ready |-> (count_q == CNT_FULL));
    a_nop_invalid: assert property (@(posedge clk) disable iff (!rst_n)
        !id_valid |-> (id_inst == NOP));

endmodule

// File: doc/mips_if2id_buf.md
Name: mips_if2id_buf

Overview:
- Two-entry skid buffer and pipeline register between the instruction fetch stage and the instruction decode stage.
- Captures the instruction word, PC and predicted-taken bit every cycle the fetch stage produces them.
- Holds them while decode is stalled, so no instruction returned by the I-cache is lost.
- Discards all buffered instructions on a flush from a branch mispredict or redirect.

Parameters:
AW, 32 (`MIPS_ADDR_WIDTH), PC width
DW, 32 (`MIPS_DATA_WIDTH), instruction width
NOP, 32'h0000_0000, instruction value driven on id_inst when id_valid=0

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard all buffered and incoming entries this cycle
if_valid  input  1  fetch presents a valid instruction
if_ready  output  1  buffer accepts this cycle; the fetch stage drives its stall input with the inverse
if_inst  input  DW  fetched instruction (I_rdata path)
if_pc  input  AW  PC of if_inst
if_prdt_taken  input  1  branch predictor decision for if_inst
id_valid  output  1  id_inst/id_pc/id_prdt_taken are valid
id_ready  input  1  decode consumes the head entry this cycle (0 = hazard stall)
id_inst  output  DW  head instruction
id_pc  output  AW  head PC
id_prdt_taken  output  1  head prediction bit
occupancy  output  2  number of valid entries, 0..2 (debug/perf)

Behaviour:
- Storage: head register (drives id_* directly) plus skid register. Count state is EMPTY (0), ONE (1) or FULL (2).
- push = if_valid & if_ready; pop = id_valid & id_ready.
- if_ready = (count != FULL). It is combinational from registered state only and never depends on if_valid or id_ready.
- id_valid = (count != EMPTY). It is a register output with no combinational path from inputs.
- id_inst = NOP whenever id_valid=0. id_pc and id_prdt_taken hold their last values when invalid; they are don't-care.
- Transitions (no flush):
  - EMPTY & push -> ONE; head <= input.
  - ONE & push & pop -> ONE; head <= input.
  - ONE & push & ~pop -> FULL; skid <= input, head unchanged.
  - ONE & ~push & pop -> EMPTY.
  - FULL & pop -> ONE; head <= skid.
  - FULL & ~pop -> FULL; all entries hold.
  - Any other combination holds state.
- if_valid while FULL is ignored: if_ready=0, so no write occurs.
- Latency: a push in cycle N is visible on id_* in N+1 if the buffer was EMPTY, or if it was ONE with a simultaneous pop. Throughput is one instruction per cycle with id_ready held high.
- Ordering is strict FIFO: the skid entry is never presented before the head entry.
- flush has priority over push and pop: next state EMPTY, id_valid=0 and if_ready=1 next cycle, and the same-cycle input is dropped. Any pop in the flush cycle still counts as consumed by decode.
- Reset, asynchronous and valid mid-operation: count=EMPTY, head/skid data=0 (id_inst=NOP, id_pc=0, id_prdt_taken=0), id_valid=0, if_ready=1, occupancy=0.
- Data registers need no reset beyond the values above. Only the count/valid state must reset.
- Arithmetic: none on data paths. occupancy is the 2-bit encoding of count.
- Assertions for verification:
  - count never 3.
  - if_ready=0 implies count=2.
  - id_valid=0 implies id_inst=NOP.

Test Plan:
- Streaming, id_ready=1: push pc 0x00,0x04,0x08 (inst 0x20080001, 0x20090002, 0x012A4020) on consecutive cycles -> each appears on id_* one cycle later in order, occupancy stays 1, if_ready stays 1.
- Stall fill: push 0x10 then 0x14 with id_ready=0 -> occupancy 2, if_ready=0, id_pc=0x10 held. Raise id_ready -> id_pc 0x10 then 0x14, if_ready=1 the cycle after the first pop.
- Push ignored when full: in FULL, drive if_valid=1 pc 0x18 with id_ready=0 -> occupancy stays 2, and 0x18 never appears on id_pc.
- Flush with simultaneous push: FULL (0x20, 0x24), assert flush with if_valid=1 pc 0x28 -> next cycle id_valid=0, id_inst=0x00000000, occupancy=0, if_ready=1. A following push of 0x40 appears next.
- Async reset mid-operation: FULL state, drop rst_n between clock edges -> id_valid=0, occupancy=0, if_ready=1 immediately without a clock edge. After release, the first push of pc 0x00 appears one cycle later.
- Random: random if_valid/id_ready/flush (flush 5%) against a queue model -> id_* stream matches the model with no loss, duplication or reordering.
